nmr_bstrm_seq_ctrl: RTL
=======================

Name: nmr_bstrm_seq_ctrl

Overview:
Program sequencer for the NMR bitstream pulse datapath. It fetches instruction words from an external synchronous-read program RAM and decodes them. It drives the datapath's START/data/PLS_POL/mux_sel inputs through a full START/DPATH_RDY/DONE handshake per pulse, and supports one hardware loop level, END and ABORT. It sits between the host-loaded program RAM and one bitstream datapath instance.

Parameters:
DATA_WIDTH, 32, pulse length / loop count field width; matches datapath.
ADDR_WIDTH, 10, program RAM address width.

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
GO  in  1  start program at address START_ADDR; sampled only in IDLE
ABORT  in  1  terminate program; priority over all decode
START_ADDR  in  ADDR_WIDTH  first instruction address
PRG_ADDR  out  ADDR_WIDTH  program RAM read address
PRG_DATA  in  DATA_WIDTH+7  instruction word; valid 1 cycle after PRG_ADDR
DP_START  out  1  to datapath START
DP_DATA  out  DATA_WIDTH  to datapath data
DP_POL  out  1  to datapath PLS_POL
DP_MUX_SEL  out  4  to datapath mux_sel
DP_RDY  in  1  from datapath DPATH_RDY
DP_DONE  in  1  from datapath DONE
BUSY  out  1  high from GO accept until return to IDLE
SEQ_DONE  out  1  one-cycle pulse on END or ABORT completion

Behaviour:
- Instruction word: [DW+6:DW+5] opcode, [DW+4] pol, [DW+3:DW] mux_sel, [DW-1:0] field.
- Opcodes: 00 PULSE; 01 LOOP_START (field = iteration count N); 10 LOOP_END; 11 END.
- Reset values: all outputs 0; PRG_ADDR 0; loop registers 0; state IDLE.
- States: IDLE, FETCH, DECODE, ISSUE, ARMED, RELEASE, DRAIN.
- IDLE: GO=1 -> PRG_ADDR<=START_ADDR, BUSY<=1, go to FETCH.
- FETCH: one wait cycle for RAM latency -> DECODE.
- DECODE:
  - PULSE: register field->DP_DATA, pol->DP_POL, mux_sel->DP_MUX_SEL; go to ISSUE.
  - LOOP_START: loop_cnt<=max(N,1); loop_addr<=PRG_ADDR+1; PRG_ADDR++ -> FETCH.
  - LOOP_END: if loop_cnt>1, loop_cnt--, PRG_ADDR<=loop_addr; else PRG_ADDR++; -> FETCH.
  - END: -> DRAIN.
- ISSUE: wait DP_RDY=1 and DP_DONE=1, then DP_START<=1 -> ARMED.
- ARMED: DP_START held 1; wait DP_DONE=0 (pulse running). Then wait DP_DONE=1 -> DP_START<=0, PRG_ADDR++ -> RELEASE. A sticky "seen low" flag separates the two phases.
- RELEASE: wait DP_RDY=1 -> FETCH.
- DRAIN: DP_START<=0; wait DP_RDY=1 and DP_DONE=1; then SEQ_DONE pulse, BUSY<=0 -> IDLE.
- DP_DATA/DP_POL/DP_MUX_SEL change only in DECODE; they are stable while DP_START=1.
- Latency: GO to DP_START=1 is 4 cycles if the first word is PULSE and the datapath is idle.
- PRG_ADDR increments wrap modulo 2^ADDR_WIDTH. A program without END runs until ABORT.
- A nested LOOP_START overwrites loop_cnt/loop_addr (single level only). LOOP_END with loop_cnt=0 falls through.
- ABORT in any non-IDLE state -> DRAIN next cycle; the in-flight pulse may be truncated only by the datapath's own behaviour. ABORT in IDLE is ignored. GO and ABORT together in IDLE: GO is ignored.
- GO while BUSY is ignored.
- RST mid-program: immediate IDLE, DP_START=0.

Optional Feature:
NMR_BSTRM_SEQ_PLS_CNT_EN:
- Defined: adds output PLS_CNT[15:0], the count of completed PULSE handshakes. It increments on the ARMED->RELEASE transition, clears on GO accept, and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. START_ADDR=0, program {PULSE pol=1 mux=0 len=5; END}, datapath model attached -> exactly one DP_START assertion, DP_DATA=5, DP_POL=1; SEQ_DONE pulses once; BUSY low afterwards.
2. Program {LOOP_START N=3; PULSE len=2; PULSE len=4 mux=2; LOOP_END; END} -> 6 pulses issued in the order 2,4,2,4,2,4 with mux 0,2,...; PLS_CNT=6 when the macro is defined.
3. LOOP_START with N=0 followed by one PULSE and LOOP_END -> the body executes exactly once.
4. ABORT asserted while in ARMED during a len=100 pulse -> DP_START=0 next cycle; SEQ_DONE only after DP_RDY=1 and DP_DONE=1; no further PRG_ADDR fetch.
5. START_ADDR=2^ADDR_WIDTH-1, PULSE at that address, END at address 0 -> address wraps to 0 and the program terminates normally.
6. RST asserted mid-pulse, then GO with the same program -> clean restart; all outputs 0 during reset; first DP_START exactly 4 cycles after GO once the datapath reports ready.

Source files
------------

// File: rtl/nmr_bstrm_seq_ctrl.sv
// Program sequencer for the NMR bitstream pulse datapath: fetches/decodes program RAM words
// and runs the START/DPATH_RDY/DONE handshake. Optional pulse counter: NMR_BSTRM_SEQ_PLS_CNT_EN.
module nmr_bstrm_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  GO,
    input  logic                  ABORT,
    input  logic [ADDR_WIDTH-1:0] START_ADDR,
    output logic [ADDR_WIDTH-1:0] PRG_ADDR,
    input  logic [DATA_WIDTH+6:0] PRG_DATA,
    output logic                  DP_START,
    output logic [DATA_WIDTH-1:0] DP_DATA,
    output logic                  DP_POL,
    output logic [3:0]            DP_MUX_SEL,
    input  logic                  DP_RDY,
    input  logic                  DP_DONE,
    output logic                  BUSY,
    output logic                  SEQ_DONE
`ifdef NMR_BSTRM_SEQ_PLS_CNT_EN
    ,
    output logic [15:0]           PLS_CNT
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        ARMED,
        RELEASE,
        DRAIN
    } state_e;

    typedef enum logic [1:0] {
        OP_PULSE      = 2'b00,
        OP_LOOP_START = 2'b01,
        OP_LOOP_END   = 2'b10,
        OP_END        = 2'b11
    } op_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] prg_addr_q;
    logic [ADDR_WIDTH-1:0] loop_addr_q;
    logic [DATA_WIDTH-1:0] loop_cnt_q;
    logic [DATA_WIDTH-1:0] dp_data_q;
    logic                  dp_start_q;
    logic                  dp_pol_q;
    logic [3:0]            dp_mux_q;
    logic                  busy_q;
    logic                  seq_done_q;
    logic                  seen_low_q;

    op_e                   instr_op;
    logic                  instr_pol;
    logic [3:0]            instr_mux;
    logic [DATA_WIDTH-1:0] instr_field;
    logic [ADDR_WIDTH-1:0] prg_addr_inc;
    logic                  dp_idle;
    logic                  abort_hit;

    assign instr_op     = op_e'(PRG_DATA[DATA_WIDTH+6:DATA_WIDTH+5]);
    assign instr_pol    = PRG_DATA[DATA_WIDTH+4];
    assign instr_mux    = PRG_DATA[DATA_WIDTH+3:DATA_WIDTH];
    assign instr_field  = PRG_DATA[DATA_WIDTH-1:0];
    assign prg_addr_inc = prg_addr_q + ADDR_WIDTH'(1);
    assign dp_idle      = DP_RDY && DP_DONE;
    // DRAIN is excluded so a held ABORT cannot stall completion of the drain.
    assign abort_hit    = ABORT && (state_q != IDLE) && (state_q != DRAIN);

`ifdef NMR_BSTRM_SEQ_PLS_CNT_EN
    logic [15:0] pls_cnt_q;
    assign PLS_CNT = pls_cnt_q;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            prg_addr_q  <= '0;
            loop_addr_q <= '0;
            loop_cnt_q  <= '0;
            dp_data_q   <= '0;
            dp_start_q  <= 1'b0;
            dp_pol_q    <= 1'b0;
            dp_mux_q    <= '0;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            seen_low_q  <= 1'b0;
`ifdef NMR_BSTRM_SEQ_PLS_CNT_EN
            pls_cnt_q   <= '0;
`endif
        end else begin
            seq_done_q <= 1'b0;
            if (abort_hit) begin
                dp_start_q <= 1'b0;
                seen_low_q <= 1'b0;
                state_q    <= DRAIN;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (GO && !ABORT) begin
                            prg_addr_q <= START_ADDR;
                            busy_q     <= 1'b1;
`ifdef NMR_BSTRM_SEQ_PLS_CNT_EN
                            pls_cnt_q  <= '0;
`endif
                            state_q    <= FETCH;
                        end
                    end
                    FETCH: begin
                        state_q <= DECODE;
                    end
                    DECODE: begin
                        case (instr_op)
                            OP_PULSE: begin
                                dp_data_q <= instr_field;
                                dp_pol_q  <= instr_pol;
                                dp_mux_q  <= instr_mux;
                                state_q   <= ISSUE;
                            end
                            OP_LOOP_START: begin
                                loop_cnt_q  <= (instr_field == '0) ? DATA_WIDTH'(1) : instr_field;
                                loop_addr_q <= prg_addr_inc;
                                prg_addr_q  <= prg_addr_inc;
                                state_q     <= FETCH;
                            end
                            OP_LOOP_END: begin
                                if (loop_cnt_q > DATA_WIDTH'(1)) begin
                                    loop_cnt_q <= loop_cnt_q - DATA_WIDTH'(1);
                                    prg_addr_q <= loop_addr_q;
                                end else begin
                                    prg_addr_q <= prg_addr_inc;
                                end
                                state_q <= FETCH;
                            end
                            default: begin
                                state_q <= DRAIN;
                            end
                        endcase
                    end
                    ISSUE: begin
                        if (dp_idle) begin
                            dp_start_q <= 1'b1;
                            seen_low_q <= 1'b0;
                            state_q    <= ARMED;
                        end
                    end
                    ARMED: begin
                        // DONE must first drop (pulse running) before its rise counts as completion.
                        if (!DP_DONE) begin
                            seen_low_q <= 1'b1;
                        end else if (seen_low_q) begin
                            dp_start_q <= 1'b0;
                            seen_low_q <= 1'b0;
                            prg_addr_q <= prg_addr_inc;
`ifdef NMR_BSTRM_SEQ_PLS_CNT_EN
                            if (pls_cnt_q != 16'hFFFF) begin
                                pls_cnt_q <= pls_cnt_q + 16'd1;
                            end
`endif
                            state_q    <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (DP_RDY) begin
                            state_q <= FETCH;
                        end
                    end
                    DRAIN: begin
                        dp_start_q <= 1'b0;
                        if (dp_idle) begin
                            seq_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign PRG_ADDR   = prg_addr_q;
    assign DP_START   = dp_start_q;
    assign DP_DATA    = dp_data_q;
    assign DP_POL     = dp_pol_q;
    assign DP_MUX_SEL = dp_mux_q;
    assign BUSY       = busy_q;
    assign SEQ_DONE   = seq_done_q;

endmodule
